// File: rtl/eq_serial_ctrl.sv
// eq_serial_ctrl
//
// Purpose:
//   Compares two W-bit words one bit per clock, LSB first, through a single
//   shared external 1-bit equality cell. Both operands are latched on an
//   accepted start. The block reports word equality and the lowest
//   mismatching bit index, and pulses done_tick for one cycle when the
//   result is ready.
//
// Configuration macro:
//   EQ_SERIAL_EARLY_EXIT_EN
//     defined   : stop at the first mismatching bit.
//     undefined : always scan all W bits (fixed latency). eq is the AND of
//                 every sampled bit_eq. mis_idx keeps the lowest mismatch.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   comparison request, only honoured while ready=1
//   a, b       in   W-bit operands, captured on the accepted start edge
//   ready      out  1 while idle and able to accept start
//   done_tick  out  one-cycle pulse when eq/mis_idx carry a new result
//   eq         out  1 = operands were equal (holds until next result)
//   mis_idx    out  lowest mismatching bit index, 0 when eq=1
//   bit_i0     out  to shared cell i0: a_reg[idx] while comparing, else 0
//   bit_i1     out  to shared cell i1: b_reg[idx] while comparing, else 0
//   bit_eq     in   shared cell result, combinational from bit_i0/bit_i1

module eq_serial_ctrl #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          ready,
  output logic          done_tick,
  output logic          eq,
  output logic [IW-1:0] mis_idx,
  output logic          bit_i0,
  output logic          bit_i1,
  input  logic          bit_eq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          prov_eq_q, prov_eq_d;
  logic [IW-1:0] prov_idx_q, prov_idx_d;
  logic          eq_q, eq_d;
  logic [IW-1:0] mis_idx_q, mis_idx_d;
  logic          ready_q, ready_d;
  logic          done_tick_q, done_tick_d;
  logic          bit_i0_q, bit_i0_d;
  logic          bit_i1_q, bit_i1_d;

`ifndef EQ_SERIAL_EARLY_EXIT_EN
  logic          scan_eq;
  logic [IW-1:0] scan_idx;
`endif

  // Next-state logic. The provisional result (prov_*) accumulates while
  // scanning. The visible eq/mis_idx are only updated on the transition
  // into DONE, so they show the previous result during a comparison.
  // All outputs are registered. Their next values are derived from the
  // next state, so the cell inputs already present bit idx on the first
  // CMP cycle.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    prov_eq_d   = prov_eq_q;
    prov_idx_d  = prov_idx_q;
    eq_d        = eq_q;
    mis_idx_d   = mis_idx_q;
    done_tick_d = 1'b0;
`ifndef EQ_SERIAL_EARLY_EXIT_EN
    scan_eq     = prov_eq_q & bit_eq;
    scan_idx    = (prov_eq_q && !bit_eq) ? idx_q : prov_idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = a;
          b_d        = b;
          idx_d      = '0;
          prov_eq_d  = 1'b1;
          prov_idx_d = '0;
          state_d    = S_CMP;
        end
      end

      S_CMP: begin
`ifdef EQ_SERIAL_EARLY_EXIT_EN
        if (!bit_eq) begin
          eq_d        = 1'b0;
          mis_idx_d   = idx_q;
          state_d     = S_DONE;
          done_tick_d = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          eq_d        = prov_eq_q;
          mis_idx_d   = prov_idx_q;
          state_d     = S_DONE;
          done_tick_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
`else
        // Only the first mismatch is recorded, because prov_eq_q drops on it.
        prov_eq_d  = scan_eq;
        prov_idx_d = scan_idx;
        if (idx_q == LAST_IDX) begin
          eq_d        = scan_eq;
          mis_idx_d   = scan_idx;
          state_d     = S_DONE;
          done_tick_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d  = (state_d == S_IDLE);
    bit_i0_d = (state_d == S_CMP) ? a_d[idx_d] : 1'b0;
    bit_i1_d = (state_d == S_CMP) ? b_d[idx_d] : 1'b0;
  end

  // Single state register for the whole controller. Reset takes priority
  // and abandons any comparison in progress without a done_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      prov_eq_q   <= 1'b0;
      prov_idx_q  <= '0;
      eq_q        <= 1'b0;
      mis_idx_q   <= '0;
      ready_q     <= 1'b1;
      done_tick_q <= 1'b0;
      bit_i0_q    <= 1'b0;
      bit_i1_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      prov_eq_q   <= prov_eq_d;
      prov_idx_q  <= prov_idx_d;
      eq_q        <= eq_d;
      mis_idx_q   <= mis_idx_d;
      ready_q     <= ready_d;
      done_tick_q <= done_tick_d;
      bit_i0_q    <= bit_i0_d;
      bit_i1_q    <= bit_i1_d;
    end
  end

  assign ready     = ready_q;
  assign done_tick = done_tick_q;
  assign eq        = eq_q;
  assign mis_idx   = mis_idx_q;
  assign bit_i0    = bit_i0_q;
  assign bit_i1    = bit_i1_q;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// tb_eq_serial_ctrl
//
// Scoreboard bench for eq_serial_ctrl. The driver predicts every accepted
// start and pushes the expected result into a queue. The expected result is
// computed from whole-word arithmetic: equality, the lowest set bit of a^b,
// and the resulting latency. A monitor on the falling edge pops the queue on
// each done_tick. Between done_ticks it checks ready, the cell inputs, and
// that eq/mis_idx hold their previous values.

module tb_eq_serial_ctrl;

  localparam int W  = 8;
  localparam int IW = 3;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          eq;
    logic [IW-1:0] mis;
    int            lat;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          done_tick;
  logic          eq;
  logic [IW-1:0] mis_idx;
  logic          bit_i0;
  logic          bit_i1;
  logic          bit_eq;

  exp_t          sb[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic          last_eq = 1'b0;
  logic [IW-1:0] last_mis = '0;

  eq_serial_ctrl #(.W(W), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done_tick (done_tick),
    .eq        (eq),
    .mis_idx   (mis_idx),
    .bit_i0    (bit_i0),
    .bit_i1    (bit_i1),
    .bit_eq    (bit_eq)
  );

  // Shared 1-bit equality cell
  assign bit_eq = ~(bit_i0 ^ bit_i1);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: whole-word view of the expected result
  function automatic exp_t modelResult(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int acc);
    exp_t          e;
    logic [W-1:0]  diff;
    diff   = ta ^ tb_v;
    e.a    = ta;
    e.b    = tb_v;
    e.eq   = (diff == '0);
    e.mis  = '0;
    e.acc  = acc;
    for (int i = W - 1; i >= 0; i--) begin
      if (diff[i]) e.mis = IW'(i);
    end
`ifdef EQ_SERIAL_EARLY_EXIT_EN
    e.lat = e.eq ? W : int'(e.mis) + 1;
`else
    e.lat = W;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  // One driver cycle: drive inputs just after the falling edge and record
  // the expected result if this start will be accepted on the next edge.
  task automatic applyStimulus(input logic st, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               output logic accepted);
    @(negedge clk);
    #1;
    start = st;
    a     = ta;
    b     = tb_v;
    accepted = st && ready && !reset;
    if (accepted) sb.push_back(modelResult(ta, tb_v, cyc + 1));
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, W'($urandom), W'($urandom), acc);
  endtask

  task automatic startAndWaitAccept(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) applyStimulus(1'b1, ta, tb_v, acc);
    if (!acc) begin
      errors++;
      $display("[TB] FAIL accept_timeout at cycle %0d: got ready=%0b expected 1", cyc, ready);
    end
  endtask

  // Monitor: sample away from the active edge and pop on done_tick
  always @(negedge clk) begin
    exp_t e;
    int   j;
    if (sb.size() > 0 && cyc >= sb[0].acc) begin
      e = sb[0];
      j = cyc - e.acc;
      if (done_tick) begin
        void'(sb.pop_front());
        checkOutput("done_latency", 32'(j), 32'(e.lat));
        checkOutput("eq", 32'(eq), 32'(e.eq));
        checkOutput("mis_idx", 32'(mis_idx), 32'(e.mis));
        checkOutput("ready_in_done", 32'(ready), 32'd0);
        last_eq  = e.eq;
        last_mis = e.mis;
      end else if (j >= e.lat) begin
        void'(sb.pop_front());
        checkOutput("done_timeout", 32'(done_tick), 32'd1);
      end else begin
        checkOutput("ready_busy", 32'(ready), 32'd0);
        checkOutput("cell_inputs", {30'd0, bit_i1, bit_i0}, {30'd0, e.b[j], e.a[j]});
        checkOutput("result_hold", {28'd0, mis_idx, eq}, {28'd0, last_mis, last_eq});
      end
    end else begin
      checkOutput("spurious_done", 32'(done_tick), 32'd0);
      checkOutput("ready_idle", 32'(ready), 32'd1);
      checkOutput("cell_idle", {30'd0, bit_i1, bit_i0}, 32'd0);
      checkOutput("result_hold", {28'd0, mis_idx, eq}, {28'd0, last_mis, last_eq});
    end
  end

  initial begin
    logic         acc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    idleCycles(5);

    // Equal words, then bit 2 mismatch, then bit 7 mismatch with an ignored start
    startAndWaitAccept(8'hA5, 8'hA5);
    idleCycles(12);
    startAndWaitAccept(8'hA5, 8'hA1);
    idleCycles(12);
    startAndWaitAccept(8'h01, 8'h81);
    idleCycles(2);
    applyStimulus(1'b1, 8'h00, 8'h00, acc);
    applyStimulus(1'b1, 8'h00, 8'h00, acc);
    idleCycles(12);

    // start held high with alternating equal/unequal pairs
    n = 0;
    ra = W'($urandom);
    rb = ra;
    for (int i = 0; i < 200 && n < 6; i++) begin
      applyStimulus(1'b1, ra, rb, acc);
      if (acc) begin
        n++;
        ra = W'($urandom);
        rb = (n % 2 == 0) ? ra : ra ^ W'(1 << $urandom_range(0, W - 1));
      end
    end
    idleCycles(12);

    // Reset in the middle of a comparison
    startAndWaitAccept(8'hA5, 8'hA5);
    idleCycles(2);
    @(negedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    sb.delete();
    last_eq  = 1'b0;
    last_mis = '0;
    @(negedge clk);
    #1 reset = 1'b0;
    idleCycles(2);
    startAndWaitAccept(8'h3C, 8'h34);
    idleCycles(12);

    // Random traffic with occasional starts while busy
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      startAndWaitAccept(ra, rb);
      for (int g = 0; g < int'($urandom_range(0, 4)); g++) begin
        applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), acc);
      end
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) idleCycles(1);
    idleCycles(2);
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
